i2s_loopback_proc: RTL and testbench
====================================

I2S_LOOPBACK_PROC -- requirements
Module: i2s_loopback_proc

Interface
REQ-001 SHALL have parameter DATA_BITS, default 24, signed two's-complement sample width.
REQ-002 SHALL have parameter DELAY_DEPTH, default 16, loopback delay in frames; power of two, >=2.
REQ-003 SHALL have parameter STARTUP_CYCLES, default 25_000_000, amp warm-up length in clk cycles.
REQ-004 SHALL have parameter MODE, default 0: 0 left-only, 1 stereo pass, 2 mono mix, 3 swap.
REQ-005 SHALL have port clk  input  1  system clock (25 MHz); sole clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports in_left_data/in_right_data  input  DATA_BITS  receiver samples.
REQ-008 SHALL have ports in_left_valid/in_right_valid  input  1  one-cycle strobes qualifying each sample.
REQ-009 SHALL have port gain_shift  input  2  left-shift gain of 0..3 (0/6/12/18 dB).
REQ-010 SHALL have ports mute  input  1 and clip_clr  input  1  (soft mute; clears sticky clip).
REQ-011 SHALL have ports out_left/out_right  output  DATA_BITS  transmitter samples.
REQ-012 SHALL have ports amp_en  output  1 (amplifier SD) and clip  output  1 (sticky saturation flag).
REQ-013 SHALL have port state  output  2  current FSM state.

Function
REQ-014 One frame SHALL be one in_right_valid strobe; the latest left sample SHALL be paired with it. If both valids fire together, the new left sample SHALL be used.
REQ-015 The FSM SHALL have states WARMUP(0), FILL(1), RUN(2); WARMUP SHALL last exactly STARTUP_CYCLES clk cycles, counted from reset release.
REQ-016 FILL SHALL advance to RUN after DELAY_DEPTH frames have been written to the delay buffer.
REQ-017 Frames arriving in WARMUP SHALL be discarded.
REQ-018 Frames SHALL be written to a circular buffer of DELAY_DEPTH pairs in FILL and RUN.
REQ-019 In RUN, each frame SHALL read the pair written DELAY_DEPTH frames earlier before overwriting that slot.
REQ-020 Write and read pointers SHALL wrap modulo DELAY_DEPTH with no full/empty stall.
REQ-021 Routing SHALL be applied to the read pair according to MODE:
  - MODE 0: L->left, 0->right.
  - MODE 1: L->left, R->right.
  - MODE 2: (L+R)>>>1 to both, computed at DATA_BITS+1 bits with an arithmetic shift.
  - MODE 3: R->left, L->right.
REQ-022 Gain SHALL be applied after routing: value<<gain_shift, saturated to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
REQ-023 Any saturation SHALL set clip the cycle after the output update.
REQ-024 clip_clr SHALL clear clip; if clear and a new saturation occur in the same cycle, set SHALL win.
REQ-025 out_left/out_right SHALL update exactly 2 clk cycles after the in_right_valid strobe (stage 1 read/route, stage 2 gain/register) and hold between frames.
REQ-026 Outputs SHALL be zero outside RUN, and zero at frame updates while mute=1; mute SHALL NOT affect amp_en, the buffer or the pointers.
REQ-027 amp_en SHALL be 1 in FILL and RUN, and 0 in WARMUP.

Reset
REQ-028 rst SHALL force the following, asynchronously, including mid-frame:
  - state=WARMUP; warm-up counter, pointers and fill count to 0.
  - out_left=out_right=0, amp_en=0, clip=0.
  - left latch cleared.
REQ-029 Buffer RAM contents SHALL need no reset, because reads occur only after FILL completes.

Configuration
REQ-030 With I2S_LOOPBACK_PEAK_EN defined, the block SHALL add output peak (DATA_BITS-1 bits): the running max of |out_left| over the current 1024-frame window, latched at each window end, reset to 0. |min| SHALL saturate to max.
REQ-031 Without I2S_LOOPBACK_PEAK_EN, the peak port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package i2s_pkg SHALL hold the MODE constants (MODE_LEFT, MODE_STEREO, MODE_MIX, MODE_SWAP) and the FSM state encodings.
REQ-033 The circular buffer SHALL be sub-module i2s_sample_delay: parameters DATA_BITS and DEPTH, 2*DATA_BITS-wide write/read, single port per frame.

Verification
REQ-034 Warm-up: STARTUP_CYCLES=100, frames every 64 cycles -> amp_en 0 until cycle 100, then 1; outputs 0 until DELAY_DEPTH frames after.
REQ-035 Delay: DELAY_DEPTH=4, MODE 1, L=n, R=-n for frame n -> in RUN, out_left=n-4 and out_right=-(n-4), each 2 cycles after the strobe.
REQ-036 Mix and swap: L=0x7FFFFF, R=0x7FFFFF, MODE 2 -> 0x7FFFFF both; L=1, R=2, MODE 3 -> out_left=2, out_right=1.
REQ-037 Saturation: gain_shift=3, L=0x100000 -> out_left=0x7FFFFF and clip=1; L=-0x100000 -> 0x800000; clip_clr clears it; clip_clr with a simultaneous clip leaves clip=1.
REQ-038 Mute and reset: mute=1 in RUN -> outputs 0 at the next frame with amp_en still 1; rst asserted mid-RUN -> all outputs 0 immediately and state=WARMUP.
REQ-039 Wrap: 3*DELAY_DEPTH+1 consecutive frames with both valids coincident -> no lost or duplicated sample across pointer wrap.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared routing modes, FSM encodings and peak window length for the I2S loopback block.
package i2s_pkg;

   localparam int MODE_LEFT   = 0;
   localparam int MODE_STEREO = 1;
   localparam int MODE_MIX    = 2;
   localparam int MODE_SWAP   = 3;

   localparam int PEAK_WINDOW = 1024;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      FILL   = 2'd1,
      RUN    = 2'd2
   } state_t;

endpackage

// File: rtl/i2s_sample_delay.sv
// i2s_sample_delay: circular store of DEPTH stereo pairs; one read-then-write access per frame at addr.
module i2s_sample_delay #(
   parameter int DATA_BITS = 24,
   parameter int DEPTH     = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [2*DATA_BITS-1:0]     wr_data,
   output logic [2*DATA_BITS-1:0]     rd_data
);

   logic [2*DATA_BITS-1:0] mem [DEPTH];
   logic [2*DATA_BITS-1:0] rd_data_q;

   // The read samples the slot's old contents before this frame overwrites it.
   always_ff @(posedge clk) begin
      if (we) begin
         rd_data_q  <= mem[addr];
         mem[addr]  <= wr_data;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/i2s_loopback_proc.sv
// i2s_loopback_proc: warm-up/fill/run loopback with frame delay, routing, gain and sticky clip.
// Define I2S_LOOPBACK_PEAK_EN to add the windowed |out_left| peak output.
module i2s_loopback_proc
   import i2s_pkg::*;
#(
   parameter int DATA_BITS      = 24,
   parameter int DELAY_DEPTH    = 16,
   parameter int STARTUP_CYCLES = 25_000_000,
   parameter int MODE           = 0
) (
`ifdef I2S_LOOPBACK_PEAK_EN
   output logic [DATA_BITS-2:0] peak,
`endif
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] in_left_data,
   input  logic [DATA_BITS-1:0] in_right_data,
   input  logic                 in_left_valid,
   input  logic                 in_right_valid,
   input  logic [1:0]           gain_shift,
   input  logic                 mute,
   input  logic                 clip_clr,
   output logic [DATA_BITS-1:0] out_left,
   output logic [DATA_BITS-1:0] out_right,
   output logic                 amp_en,
   output logic                 clip,
   output logic [1:0]           state
);

   localparam int DW = DATA_BITS;
   localparam int AW = $clog2(DELAY_DEPTH);
   localparam int WW = $clog2(STARTUP_CYCLES + 1);

   function automatic logic [DW:0] gain_sat(input logic [DW-1:0] v, input logic [1:0] sh);
      logic [DW+2:0] x;
      x = {{3{v[DW-1]}}, v} << sh;
      return (&x[DW+2:DW-1] || ~|x[DW+2:DW-1]) ? {1'b0, x[DW-1:0]}
                                               : {1'b1, x[DW+2], {(DW-1){~x[DW+2]}}};
   endfunction

   state_t          state_q;
   logic [WW-1:0]   warm_q;
   logic [AW-1:0]   ptr_q;
   logic [AW:0]     fill_q;
   logic            amp_en_q;
   logic [DW-1:0]   left_q, left_d;
   logic            s1_vld_q, s1_vld_d;
   logic [DW-1:0]   out_left_q, out_left_d, out_right_q, out_right_d;
   logic            sat_q, sat_d, clip_q, clip_d;
   logic [2*DW-1:0] rd_data;
   logic [DW-1:0]   rd_l, rd_r, mix, rt_l, rt_r;
   logic [DW:0]     mix_sum, gl, gr;
   logic            store;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= WARMUP;
         warm_q   <= '0;
         ptr_q    <= '0;
         fill_q   <= '0;
         amp_en_q <= 1'b0;
      end else begin
         case (state_q)
            WARMUP: begin
               if (warm_q == WW'(STARTUP_CYCLES - 1)) begin
                  state_q  <= FILL;
                  amp_en_q <= 1'b1;
               end else begin
                  warm_q <= warm_q + 1'b1;
               end
            end
            FILL: begin
               if (in_right_valid) begin
                  ptr_q  <= ptr_q + 1'b1;
                  fill_q <= fill_q + 1'b1;
                  if (fill_q == (AW+1)'(DELAY_DEPTH - 1)) state_q <= RUN;
               end
            end
            RUN: begin
               if (in_right_valid) ptr_q <= ptr_q + 1'b1;
            end
            default: state_q <= WARMUP;
         endcase
      end
   end

   assign store = in_right_valid && state_q != WARMUP;

   i2s_sample_delay #(
      .DATA_BITS (DW),
      .DEPTH     (DELAY_DEPTH)
   ) u_delay (
      .clk     (clk),
      .we      (store),
      .addr    (ptr_q),
      .wr_data ({left_d, in_right_data}),
      .rd_data (rd_data)
   );

   assign rd_l    = rd_data[2*DW-1:DW];
   assign rd_r    = rd_data[DW-1:0];
   assign mix_sum = {rd_l[DW-1], rd_l} + {rd_r[DW-1], rd_r};
   assign mix     = DW'($signed(mix_sum) >>> 1);

   always_comb begin
      left_d      = in_left_valid ? in_left_data : left_q;
      s1_vld_d    = in_right_valid && state_q == RUN;
      rt_l        = MODE == MODE_SWAP ? rd_r : MODE == MODE_MIX ? mix : rd_l;
      rt_r        = MODE == MODE_LEFT ? '0 : MODE == MODE_STEREO ? rd_r : MODE == MODE_MIX ? mix : rd_l;
      gl          = gain_sat(rt_l, gain_shift);
      gr          = gain_sat(rt_r, gain_shift);
      out_left_d  = s1_vld_q ? (mute ? '0 : gl[DW-1:0]) : out_left_q;
      out_right_d = s1_vld_q ? (mute ? '0 : gr[DW-1:0]) : out_right_q;
      sat_d       = s1_vld_q && (gl[DW] || gr[DW]);
      clip_d      = sat_q || (clip_q && !clip_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_q      <= '0;
         s1_vld_q    <= 1'b0;
         out_left_q  <= '0;
         out_right_q <= '0;
         sat_q       <= 1'b0;
         clip_q      <= 1'b0;
      end else begin
         left_q      <= left_d;
         s1_vld_q    <= s1_vld_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         sat_q       <= sat_d;
         clip_q      <= clip_d;
      end
   end

`ifdef I2S_LOOPBACK_PEAK_EN
   localparam int PW = $clog2(PEAK_WINDOW);

   logic [PW-1:0]   win_q, win_d;
   logic [DW-2:0]   run_max_q, run_max_d, peak_q, peak_d, abs_v, cur_max;
   logic [DW-1:0]   neg_v;
   logic            win_end;

   // -MIN wraps back to MIN, so its set sign bit marks the case that saturates.
   always_comb begin
      neg_v     = -out_left_d;
      abs_v     = !out_left_d[DW-1] ? out_left_d[DW-2:0] : neg_v[DW-1] ? '1 : neg_v[DW-2:0];
      cur_max   = abs_v > run_max_q ? abs_v : run_max_q;
      win_end   = s1_vld_q && &win_q;
      win_d     = s1_vld_q ? win_q + 1'b1 : win_q;
      run_max_d = s1_vld_q ? (win_end ? '0 : cur_max) : run_max_q;
      peak_d    = win_end ? cur_max : peak_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q     <= '0;
         run_max_q <= '0;
         peak_q    <= '0;
      end else begin
         win_q     <= win_d;
         run_max_q <= run_max_d;
         peak_q    <= peak_d;
      end
   end

   assign peak = peak_q;
`endif

   assign out_left  = out_left_q;
   assign out_right = out_right_q;
   assign amp_en    = amp_en_q;
   assign clip      = clip_q;
   assign state     = state_q;

endmodule

// File: tb/tb_i2s_loopback_proc.sv
// tb_i2s_loopback_proc: drives one DUT per MODE in parallel and scores outputs against a frame-delay model.
module tb_i2s_loopback_proc;

   localparam int DB = 24;
   localparam int D  = 4;
   localparam int SC = 100;

   typedef struct packed {
      logic [3:0][23:0] l;
      logic [3:0][23:0] r;
      logic [3:0]       s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] ldata = '0, rdata = '0;
   logic        lvalid = 1'b0, rvalid = 1'b0;
   logic [1:0]  gain = 2'd0;
   logic        mute = 1'b0, clr = 1'b0;
   logic [23:0] out_l [4];
   logic [23:0] out_r [4];
   logic        amp [4];
   logic        clip [4];
   logic [1:0]  st [4];

   exp_t        sb [$];
   logic [47:0] hist [$];
   int          mf;
   logic [23:0] lat;
   logic [23:0] prev_l [4];
   logic [23:0] prev_r [4];
   logic        clip_m [4];
   int          checks = 0, errors = 0;
   int          edges = 0;

   always #5 clk = ~clk;

   always @(posedge clk) edges <= rst ? 0 : edges + 1;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dut
         i2s_loopback_proc #(
            .DATA_BITS      (DB),
            .DELAY_DEPTH    (D),
            .STARTUP_CYCLES (SC),
            .MODE           (g)
         ) dut (
            .clk            (clk),
            .rst            (rst),
            .in_left_data   (ldata),
            .in_right_data  (rdata),
            .in_left_valid  (lvalid),
            .in_right_valid (rvalid),
            .gain_shift     (gain),
            .mute           (mute),
            .clip_clr       (clr),
            .out_left       (out_l[g]),
            .out_right      (out_r[g]),
            .amp_en         (amp[g]),
            .clip           (clip[g]),
            .state          (st[g])
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sx(input logic [23:0] v);
      return int'($signed(v));
   endfunction

   function automatic int clamp(input int x);
      return x > 8388607 ? 8388607 : x < -8388608 ? -8388608 : x;
   endfunction

   function automatic exp_t model(input logic [47:0] p);
      exp_t e;
      int lv, rv, a, b, xa, xb;
      lv = sx(p[47:24]);
      rv = sx(p[23:0]);
      for (int m = 0; m < 4; m++) begin
         case (m)
            0:       begin a = lv; b = 0; end
            1:       begin a = lv; b = rv; end
            2:       begin a = (lv + rv) >>> 1; b = a; end
            default: begin a = rv; b = lv; end
         endcase
         xa = a * (1 << gain);
         xb = b * (1 << gain);
         e.s[m] = (clamp(xa) != xa) || (clamp(xb) != xb);
         e.l[m] = mute ? 24'd0 : 24'(clamp(xa));
         e.r[m] = mute ? 24'd0 : 24'(clamp(xb));
      end
      return e;
   endfunction

   task automatic model_reset();
      mf = 0;
      lat = '0;
      hist.delete();
      sb.delete();
      for (int m = 0; m < 4; m++) begin
         prev_l[m] = '0;
         prev_r[m] = '0;
         clip_m[m] = 1'b0;
      end
   endtask

   // lv: 0 = no left strobe (latched left reused), 1 = left strobe earlier, 2 = both strobes together
   task automatic send(input logic [23:0] l, input logic [23:0] r, input int lv, input bit clr_mid);
      exp_t e;
      bit   has;
      if (lv == 1) begin
         @(negedge clk);
         lvalid = 1'b1; ldata = l; lat = l;
         @(negedge clk);
         lvalid = 1'b0; ldata = 24'($urandom);
      end
      @(negedge clk);
      for (int m = 0; m < 4; m++) chk("amp_en", 32'(amp[m]), 32'(edges >= SC));
      chk("state", 32'(st[1]), edges < SC ? 0 : mf >= D ? 2 : 1);
      rdata = r; rvalid = 1'b1;
      if (lv == 2) begin
         lvalid = 1'b1; ldata = l; lat = l;
      end
      has = 1'b0;
      e = '0;
      if (edges >= SC) begin
         if (mf < D) mf++;
         else begin
            sb.push_back(model(hist.pop_front()));
            has = 1'b1;
         end
         hist.push_back({lat, r});
      end
      @(posedge clk);
      @(negedge clk);
      lvalid = 1'b0; rvalid = 1'b0; ldata = 24'($urandom); rdata = 24'($urandom);
      for (int m = 0; m < 4; m++) chk("hold_l", 32'(out_l[m]), 32'(prev_l[m]));
      @(posedge clk);
      #1;
      if (has) begin
         e = sb.pop_front();
         for (int m = 0; m < 4; m++) begin
            prev_l[m] = e.l[m];
            prev_r[m] = e.r[m];
         end
      end
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("out_l m%0d", m), 32'(out_l[m]), 32'(prev_l[m]));
         chk($sformatf("out_r m%0d", m), 32'(out_r[m]), 32'(prev_r[m]));
      end
      if (clr_mid) clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int m = 0; m < 4; m++) begin
         clip_m[m] = (has && e.s[m]) ? 1'b1 : clr_mid ? 1'b0 : clip_m[m];
         chk($sformatf("clip m%0d", m), 32'(clip[m]), 32'(clip_m[m]));
      end
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int m = 0; m < 4; m++) begin
         clip_m[m] = 1'b0;
         chk("clip_clr", 32'(clip[m]), 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int m = 0; m < 4; m++) begin
         chk({tag, " out_l"}, 32'(out_l[m]), 0);
         chk({tag, " out_r"}, 32'(out_r[m]), 0);
         chk({tag, " amp_en"}, 32'(amp[m]), 0);
         chk({tag, " clip"}, 32'(clip[m]), 0);
         chk({tag, " state"}, 32'(st[m]), 0);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         send(24'(i + 1), 24'(-(i + 1)), 1, 1'b0);
         repeat (56) @(negedge clk);
      end

      for (int i = 9; i < 19; i++) send(24'(i), 24'(-i), (i % 2) ? 1 : 2, 1'b0);

      repeat (D + 1) send(24'h7FFFFF, 24'h7FFFFF, 2, 1'b0);
      send(24'hFFFFFD, 24'h000004, 1, 1'b0);
      repeat (D + 1) send(24'd1, 24'd2, 1, 1'b0);

      gain = 2'd3;
      send(24'h100000, 24'd0, 1, 1'b0);
      send(24'hF00000, 24'd0, 1, 1'b0);
      repeat (D - 2) send(24'd0, 24'd0, 2, 1'b0);
      send(24'd0, 24'd0, 2, 1'b0);
      clr_pulse();
      send(24'd0, 24'd0, 2, 1'b1);
      clr_pulse();
      gain = 2'd0;

      mute = 1'b1;
      repeat (D + 2) send(24'($urandom), 24'($urandom), 2, 1'b0);
      mute = 1'b0;

      for (int i = 0; i < 3 * D + 1; i++) begin
         gain = 2'($urandom_range(0, 3));
         send(24'($urandom), 24'($urandom), 2, 1'b0);
      end
      gain = 2'd0;
      send(24'h123456, 24'h654321, 2, 1'b0);

      @(negedge clk);
      rdata = 24'h5; rvalid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      rvalid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      repeat (SC) @(negedge clk);
      for (int i = 0; i < D + 2; i++) begin
         ldata = 24'h0ABCDE;
         send(24'd0, 24'(100 + i), 0, 1'b0);
      end

      chk("sb_empty", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
